pipe_stage_skid: RTL

//  Parametrised, elastic pipeline-stage register. It is the successor to the fixed ID/EXE-style stage registers.

---
 rtl/pipe_stage_skid.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: elastic pipeline register with a 2-entry skid buffer,
// freeze/flush controls and saturating stall/bubble counters.
// Ports:
//   clk, rst (sync, active-low)
//   in_valid/in_ready/in_ctrl/in_data     : upstream handshake + payload
//   out_valid/out_ready/out_ctrl/out_data : downstream handshake + payload
//   freeze, flush, cnt_clr                : pipeline / counter controls
//   occupancy, stall_cnt, bubble_cnt      : status and performance counters
module pipe_stage_skid #(
  parameter int CTRL_W = 8,
  parameter int DATA_W = 128,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  input  logic              freeze,
  input  logic              flush,
  input  logic              cnt_clr,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [CTRL_W-1:0] r_main_ctrl;
  logic [DATA_W-1:0] r_main_data;
  logic [CTRL_W-1:0] r_skid_ctrl;
  logic [DATA_W-1:0] r_skid_data;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic [CNT_W-1:0]  r_bubble_cnt;

  logic w_main_valid;
  logic w_skid_valid;
  logic w_in_fire;
  logic w_out_fire;
  logic w_ld_main_in;
  logic w_ld_skid_in;
  logic w_ld_main_skid;
  logic w_clr_main_ctrl;
  logic w_stall_hit;
  logic w_bubble_hit;

  assign w_main_valid = (r_state != S_EMPTY);
  assign w_skid_valid = (r_state == S_FULL);

  // Registered-only ready: no path from out_ready.
  assign in_ready   = rst & ~w_skid_valid & ~freeze & ~flush;
  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = w_main_valid & out_ready & ~freeze & ~flush;

  assign out_valid  = w_main_valid;
  assign out_ctrl   = r_main_ctrl;
  assign out_data   = r_main_data;
  assign occupancy  = r_state;
  assign stall_cnt  = r_stall_cnt;
  assign bubble_cnt = r_bubble_cnt;

  always_comb begin
    w_state_nxt     = r_state;
    w_ld_main_in    = 1'b0;
    w_ld_skid_in    = 1'b0;
    w_ld_main_skid  = 1'b0;
    w_clr_main_ctrl = 1'b0;
    if (flush) begin
      w_state_nxt = S_EMPTY;
    end else begin
      unique case (r_state)
        S_EMPTY: begin
          if (w_in_fire) begin
            w_ld_main_in = 1'b1;
            w_state_nxt  = S_ONE;
          end
        end
        S_ONE: begin
          unique case (1'b1)
            w_in_fire & w_out_fire: begin
              w_ld_main_in = 1'b1;
            end
            w_in_fire & ~w_out_fire: begin
              w_ld_skid_in = 1'b1;
              w_state_nxt  = S_FULL;
            end
            ~w_in_fire & w_out_fire: begin
              w_clr_main_ctrl = 1'b1;
              w_state_nxt     = S_EMPTY;
            end
            default: begin
            end
          endcase
        end
        S_FULL: begin
          if (w_out_fire) begin
            w_ld_main_skid = 1'b1;
            w_state_nxt    = S_ONE;
          end
        end
        default: begin
          w_state_nxt = S_EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // CTRL is zeroed whenever its entry empties; DATA only on reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_main_ctrl <= '0;
      r_main_data <= '0;
      r_skid_ctrl <= '0;
      r_skid_data <= '0;
    end else if (flush) begin
      r_main_ctrl <= '0;
      r_skid_ctrl <= '0;
    end else begin
      if (w_ld_main_in) begin
        r_main_ctrl <= in_ctrl;
        r_main_data <= in_data;
      end
      if (w_ld_main_skid) begin
        r_main_ctrl <= r_skid_ctrl;
        r_main_data <= r_skid_data;
        r_skid_ctrl <= '0;
      end
      if (w_clr_main_ctrl) begin
        r_main_ctrl <= '0;
      end
      if (w_ld_skid_in) begin
        r_skid_ctrl <= in_ctrl;
        r_skid_data <= in_data;
      end
    end
  end

  assign w_stall_hit  = w_main_valid & (~out_ready | freeze);
  assign w_bubble_hit = ~w_main_valid;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_stall_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else if (cnt_clr) begin
      r_stall_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else begin
      if (w_stall_hit && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
      if (w_bubble_hit && (r_bubble_cnt != '1)) begin
        r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
      end
    end
  end

endmodule
